// File: rtl/ssd_driver_if.sv
// rtl/ssd_driver_if.sv - display value/dp inputs and anode/cathode outputs of the 4-digit driver
//   value[15:0] : hex value, nibble n shown on digit n (digit 0 rightmost)
//   dp[3:0]     : decimal point enables, active-high, bit n for digit n
//   an[3:0]     : digit anodes, active-low
//   seg[6:0]    : cathodes a..g, active-low
//   dp_n        : decimal point cathode, active-low
interface ssd_driver_if;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  modport master (output value, output dp, input an, input seg, input dp_n);
  modport slave  (input value, input dp, output an, output seg, output dp_n);
endinterface

// File: rtl/ssd_driver.sv
// rtl/ssd_driver.sv - multiplexed 4-digit seven-segment driver with frame-synchronous shadow load
//   Ports: clk (single clock), rst (synchronous, active-high),
//          bus (ssd_driver_if.slave: value/dp in, an/seg/dp_n out, all outputs registered).
//   Parameters: REFRESH_CYCLES (2..65536) cycles per digit slot,
//               BLANK_CYCLES (0..REFRESH_CYCLES-1) dark cycles at the start of every slot.
//   Optional: define SSD_LZB_EN to blank leading zeros on digits 3..1.
module ssd_driver #(
  parameter int REFRESH_CYCLES = 50000,
  parameter int BLANK_CYCLES   = 1000
) (
  input  logic         clk,
  input  logic         rst,
  ssd_driver_if.slave  bus
);

  localparam logic [15:0] LP_TC    = 16'(REFRESH_CYCLES - 1);
  // One extra bit so BLANK_CYCLES up to 65535 compares against the full counter range.
  localparam logic [16:0] LP_BLANK = 17'(BLANK_CYCLES);

  logic [15:0] r_cnt;
  logic [1:0]  r_idx;
  logic [15:0] r_sh_val;
  logic [3:0]  r_sh_dp;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp_n;

  logic        w_tick;
  logic        w_blank_slot;
  logic [3:0]  w_nib;
  logic [3:0]  w_lz;
  logic [3:0]  w_an_nxt;
  logic [6:0]  w_seg_nxt;
  logic        w_dp_n_nxt;

  // Active-high gfedcba glyphs.
  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h3F;
      4'h1: font = 7'h06;
      4'h2: font = 7'h5B;
      4'h3: font = 7'h4F;
      4'h4: font = 7'h66;
      4'h5: font = 7'h6D;
      4'h6: font = 7'h7D;
      4'h7: font = 7'h07;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h6F;
      4'hA: font = 7'h77;
      4'hB: font = 7'h7C;
      4'hC: font = 7'h39;
      4'hD: font = 7'h5E;
      4'hE: font = 7'h79;
      default: font = 7'h71;
    endcase
  endfunction

  assign w_tick       = (r_cnt == LP_TC);
  assign w_blank_slot = ({1'b0, r_cnt} < LP_BLANK);

  always_comb begin
    w_nib = 4'h0;
    case (r_idx)
      2'd0: w_nib = r_sh_val[3:0];
      2'd1: w_nib = r_sh_val[7:4];
      2'd2: w_nib = r_sh_val[11:8];
      default: w_nib = r_sh_val[15:12];
    endcase
  end

`ifdef SSD_LZB_EN
  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    w_lz    = 4'b0000;
    w_lz[3] = (r_sh_val[15:12] == 4'h0);
    w_lz[2] = w_lz[3] && (r_sh_val[11:8] == 4'h0);
    w_lz[1] = w_lz[2] && (r_sh_val[7:4] == 4'h0);
  end
`else
  assign w_lz = 4'b0000;
`endif

  always_comb begin
    w_an_nxt   = 4'b1111;
    w_seg_nxt  = 7'h7F;
    w_dp_n_nxt = 1'b1;
    if (!w_blank_slot) begin
      w_dp_n_nxt = ~r_sh_dp[r_idx];
      if (!w_lz[r_idx]) begin
        w_an_nxt  = ~(4'b0001 << r_idx);
        w_seg_nxt = ~font(w_nib);
      end else if (r_sh_dp[r_idx]) begin
        // Blanked digit still lights its decimal point; segments stay dark.
        w_an_nxt = ~(4'b0001 << r_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 16'h0000;
      r_idx    <= 2'd0;
      r_sh_val <= 16'h0000;
      r_sh_dp  <= 4'h0;
      r_an     <= 4'b1111;
      r_seg    <= 7'h7F;
      r_dp_n   <= 1'b1;
    end else begin
      r_cnt <= w_tick ? 16'h0000 : r_cnt + 16'h0001;
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end
      // Shadow reloads only at the frame boundary so a frame is never torn.
      if (w_tick && (r_idx == 2'd3)) begin
        r_sh_val <= bus.value;
        r_sh_dp  <= bus.dp;
      end
      r_an   <= w_an_nxt;
      r_seg  <= w_seg_nxt;
      r_dp_n <= w_dp_n_nxt;
    end
  end

  assign bus.an   = r_an;
  assign bus.seg  = r_seg;
  assign bus.dp_n = r_dp_n;

endmodule
